// File: rtl/fifo_uart_tx.sv
// UART transmitter: pops one word per frame from a show-ahead TX FIFO and
// serialises it as start / DBIT data bits (LSB first) / stop, paced by a 16x baud tick.
//   state | meaning
//   IDLE  | line high, waiting for a non-empty FIFO
//   START | start bit (line low) for 16 ticks
//   DATA  | shifting out DBIT data bits, 16 ticks each
//   STOP  | stop bit (line high) for SB_TICK ticks
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_BIT_LAST  = 5'd15;
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;

  assign fifo_rd = (state == IDLE) & ~fifo_empty;
  assign tx_busy = (state != IDLE);

  // tx is loaded with the value the line must carry in the next state, so it never glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            b     <= fifo_data;
            s     <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              n     <= '0;
              tx    <= b[0];
              state <= DATA;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                n  <= n + 1'b1;
                tx <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (s == S_STOP_LAST) begin
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (8N1, 8 data + 2 stop, 7 data bits)
// share clock, reset and a tick every 4 clk; each is fed by a small queue-backed FIFO.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s_tick = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       e8, e32, e7;
  logic [7:0] d8, d32;
  logic [6:0] d7;
  logic       rd8, rd32, rd7, tx8, tx32, tx7;
  logic       busy8, busy32, busy7, dn8, dn32, dn7;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(e8), .fifo_data(d8),
    .fifo_rd(rd8), .tx(tx8), .tx_busy(busy8), .tx_done_tick(dn8));
  fifo_uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(e32), .fifo_data(d32),
    .fifo_rd(rd32), .tx(tx32), .tx_busy(busy32), .tx_done_tick(dn32));
  fifo_uart_tx #(.DBIT(7), .SB_TICK(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(e7), .fifo_data(d7),
    .fifo_rd(rd7), .tx(tx7), .tx_busy(busy7), .tx_done_tick(dn7));

  logic [7:0] q8[$];
  logic [7:0] q32[$];
  logic [7:0] q7[$];
  logic tog7 = 1'b0;
  int pops8 = 0, pops32 = 0, pops7 = 0;
  int done8 = 0, done32 = 0, done7 = 0;

  int   sel = 0;
  logic tx_m, rd_m, busy_m, dn_m;
  always_comb begin
    tx_m = tx8; rd_m = rd8; busy_m = busy8; dn_m = dn8;
    if (sel == 1) begin
      tx_m = tx32; rd_m = rd32; busy_m = busy32; dn_m = dn32;
    end else if (sel == 2) begin
      tx_m = tx7; rd_m = rd7; busy_m = busy7; dn_m = dn7;
    end
  end

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk); #1;
      c = (c + 1) % 4;
      s_tick = (c == 0);
    end
  end

  // show-ahead FIFO model: head word is presented until the cycle after a pop
  initial begin : fifo_model
    logic p8, p32, p7;
    e8 = 1'b1; e32 = 1'b1; e7 = 1'b1; d8 = '0; d32 = '0; d7 = '0;
    forever begin
      @(negedge clk);
      p8 = rd8; p32 = rd32; p7 = rd7;
      if (rd8) pops8++;
      if (rd32) pops32++;
      if (rd7) pops7++;
      if (dn8) done8++;
      if (dn32) done32++;
      if (dn7) done7++;
      @(posedge clk); #1;
      if (p8 && q8.size() > 0) void'(q8.pop_front());
      if (p32 && q32.size() > 0) void'(q32.pop_front());
      if (p7 && q7.size() > 0) void'(q7.pop_front());
      e8  = (q8.size() == 0);
      e32 = (q32.size() == 0);
      e7  = (q7.size() == 0) ^ tog7;
      d8  = (q8.size() > 0) ? q8[0] : 8'h00;
      d32 = (q32.size() > 0) ? q32[0] : 8'h00;
      d7  = (q7.size() > 0) ? q7[0][6:0] : 7'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // waits for the start bit on the selected line, then decodes one frame mid-bit
  task automatic capture(input int dbit, output logic [7:0] data, output int ticks, output int gap);
    int cyc, extra;
    data = 8'h00; ticks = 0; gap = 0; cyc = 0; extra = 0;
    while (tx_m !== 1'b0 && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    chk("frame_start", tx_m, 0);
    chk("busy_rise", busy_m, 1);
    while (dn_m !== 1'b1 && cyc < 4000) begin
      if (s_tick) ticks++;
      if (rd_m) extra++;
      if (cyc == 32) chk("start_bit", tx_m, 0);
      for (int k = 1; k <= dbit; k++)
        if (cyc == 32 + 64 * k) data[k-1] = tx_m;
      if (cyc == 32 + 64 * (dbit + 1)) chk("stop_bit", tx_m, 1);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", dn_m, 1);
    chk("tx_idle_at_done", tx_m, 1);
    chk("busy_fall", busy_m, 0);
    chk("no_midframe_rd", extra, 0);
  endtask

  initial begin : main
    logic [7:0] data;
    int ticks, gap, bad, p0, d0, w;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_rd", rd8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", dn8, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || rd8 !== 1'b0 || busy8 !== 1'b0 || dn8 !== 1'b0) bad++;
    end
    chk("idle_window", bad, 0);

    // single byte 0xA5
    sel = 0; p0 = pops8; d0 = done8;
    q8.push_back(8'hA5);
    capture(8, data, ticks, gap);
    chk("single_data", data, 8'hA5);
    chk("single_ticks", ticks, 160);
    repeat (4) @(negedge clk);
    chk("single_pops", pops8 - p0, 1);
    chk("single_done", done8 - d0, 1);

    // back-to-back frames
    p0 = pops8; d0 = done8;
    q8.push_back(8'h00); q8.push_back(8'hFF); q8.push_back(8'h55);
    capture(8, data, ticks, gap);
    chk("b2b_data0", data, 8'h00);
    capture(8, data, ticks, gap);
    chk("b2b_data1", data, 8'hFF);
    chk("b2b_gap1", (gap >= 1 && gap < 4), 1);
    capture(8, data, ticks, gap);
    chk("b2b_data2", data, 8'h55);
    chk("b2b_gap2", (gap >= 1 && gap < 4), 1);
    chk("b2b_ticks2", ticks, 160);
    repeat (4) @(negedge clk);
    chk("b2b_pops", pops8 - p0, 3);
    chk("b2b_done", done8 - d0, 3);

    // two stop bits
    sel = 1; p0 = pops32;
    q32.push_back(8'h3C);
    capture(8, data, ticks, gap);
    chk("sb32_data", data, 8'h3C);
    chk("sb32_ticks", ticks, 176);
    repeat (4) @(negedge clk);
    chk("sb32_pops", pops32 - p0, 1);

    // reset during data bit 3
    sel = 0; p0 = pops8; d0 = done8;
    q8.push_back(8'hC3);
    w = 0;
    while (tx8 !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (64 * 4 + 32) @(negedge clk);
    chk("pre_reset_bit3", tx8, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx8, 1);
    chk("rst_mid_busy", busy8, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    q8.push_back(8'h96);
    capture(8, data, ticks, gap);
    chk("post_rst_data", data, 8'h96);
    chk("post_rst_ticks", ticks, 160);
    repeat (4) @(negedge clk);
    chk("rst_pops", pops8 - p0, 2);
    chk("rst_done", done8 - d0, 1);

    // 7 data bits with fifo_empty toggling mid-frame
    sel = 2; p0 = pops7;
    q7.push_back(8'h5A);
    fork
      capture(7, data, ticks, gap);
      begin
        repeat (60) @(negedge clk); tog7 = 1'b1;
        repeat (100) @(negedge clk); tog7 = 1'b0;
        repeat (100) @(negedge clk); tog7 = 1'b1;
        repeat (100) @(negedge clk); tog7 = 1'b0;
      end
    join
    chk("d7_data", data, 8'h5A);
    chk("d7_ticks", ticks, 144);
    repeat (4) @(negedge clk);
    chk("d7_pops", pops7 - p0, 1);
    chk("d7_idle_tx", tx7, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
